// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the N-slave Wishbone interconnect.
package wb_ic_pkg;

  localparam int ADR_W = 32;
  localparam logic [ADR_W-1:0] ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    ERR_ACK  = 2'd2,
    ERR_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/wishbone_interconnect_n_if.sv
// Bus bundle between one Wishbone master, the interconnect and NUM_SLAVES slaves.
interface wishbone_interconnect_n_if #(
  parameter int NUM_SLAVES = 2
);
  // Classic Wishbone: a transfer is offered while cyc & stb are high and
  // completes in the cycle ack is high; the master must drop or advance stb
  // after each ack, and a new request is one strobe per ack.
  logic                    m_we_i;
  logic                    m_cyc_i;
  logic                    m_stb_i;
  logic [31:0]             m_adr_i;
  logic [31:0]             m_dat_i;
  logic [31:0]             m_dat_o;
  logic                    m_ack_o;
  logic                    m_int_o;
  logic [NUM_SLAVES-1:0]   s_we_o;
  logic [NUM_SLAVES-1:0]   s_cyc_o;
  logic [NUM_SLAVES-1:0]   s_stb_o;
  logic [31:0]             s_adr_o;
  logic [31:0]             s_dat_o;
  logic [32*NUM_SLAVES-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]   s_ack_i;
  logic [NUM_SLAVES-1:0]   s_int_i;
  logic                    bus_err_o;
  logic [31:0]             err_adr_o;

  // Interconnect view.
  modport slave (
    input  m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_int_i,
    output m_dat_o, m_ack_o, m_int_o, s_we_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o,
           bus_err_o, err_adr_o
  );

  // Environment view: the master plus the slave set.
  modport master (
    output m_we_i, m_cyc_i, m_stb_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_int_i,
    input  m_dat_o, m_ack_o, m_int_o, s_we_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o,
           bus_err_o, err_adr_o
  );
endinterface

// File: rtl/wb_ic_decode.sv
// Combinational slave-select extraction and range check.
module wb_ic_decode
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_LSB    = 24
) (
  input  logic [ADR_W-1:0]         adr,
  output logic [ADR_W-SEL_LSB-1:0] sel_idx,
  output logic                     sel_valid
);

  assign sel_idx   = adr[ADR_W-1:SEL_LSB];
  assign sel_valid = 32'(sel_idx) < 32'(NUM_SLAVES);

endmodule

// File: rtl/wishbone_interconnect_n.sv
// Single-master, N-slave Wishbone interconnect with latched decode and error ack.
// Optional bus-timeout watchdog enabled by defining WB_IC_TIMEOUT_EN.
module wishbone_interconnect_n
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_LSB        = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  wishbone_interconnect_n_if.slave    bus,
  output state_t                      fsm_state
);

  localparam int SEL_W = ADR_W - SEL_LSB;
  localparam logic [ADR_W-1:0] ADR_MASK = (32'd1 << SEL_LSB) - 32'd1;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      sel, sel_idx;
  logic                  sel_valid;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  slave_ack;
  logic [31:0]           slave_dat;
  logic                  capture_err;
  logic                  timeout;

  wb_ic_decode #(.NUM_SLAVES(NUM_SLAVES), .SEL_LSB(SEL_LSB)) u_decode (
    .adr       (bus.m_adr_i),
    .sel_idx   (sel_idx),
    .sel_valid (sel_valid)
  );

  // Mux keyed by the latched select, never the live address field.
  always_comb begin
    sel_oh    = '0;
    slave_dat = ERR_DATA;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_oh[k] = 1'b1;
        slave_dat = bus.s_dat_i[32*k +: 32];
      end
    end
  end

  assign slave_ack   = |(bus.s_ack_i & sel_oh);
  assign bus.s_adr_o = bus.m_adr_i & ADR_MASK;
  assign bus.s_dat_o = bus.m_dat_i;
  assign fsm_state   = state;

`ifdef WB_IC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wd_cnt;

  assign timeout = (state == ACTIVE) && bus.m_cyc_i && bus.m_stb_i && !slave_ack &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ACTIVE || state_nxt != ACTIVE || slave_ack) begin
      wd_cnt <= '0;
    end else if (bus.m_stb_i) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    capture_err   = 1'b0;
    bus.s_cyc_o   = '0;
    bus.s_stb_o   = '0;
    bus.s_we_o    = '0;
    bus.m_ack_o   = 1'b0;
    bus.m_dat_o   = ERR_DATA;
    bus.bus_err_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          state_nxt   = sel_valid ? ACTIVE : ERR_ACK;
          capture_err = !sel_valid;
        end
      end
      ACTIVE: begin
        bus.s_cyc_o = sel_oh & {NUM_SLAVES{bus.m_cyc_i}};
        bus.s_stb_o = sel_oh & {NUM_SLAVES{bus.m_stb_i}};
        bus.s_we_o  = sel_oh & {NUM_SLAVES{bus.m_we_i}};
        bus.m_ack_o = slave_ack;
        bus.m_dat_o = slave_dat;
        if (!bus.m_cyc_i) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt   = ERR_ACK;
          capture_err = 1'b1;
        end
      end
      ERR_ACK: begin
        bus.m_ack_o   = 1'b1;
        bus.bus_err_o = 1'b1;
        state_nxt     = ERR_WAIT;
      end
      ERR_WAIT: begin
        if (!bus.m_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.m_stb_i) begin
          state_nxt = ERR_ACK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      bus.err_adr_o <= '0;
      bus.m_int_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.m_int_o <= |bus.s_int_i;
      if (state == IDLE && bus.m_cyc_i && bus.m_stb_i) begin
        sel <= sel_idx;
      end
      if (capture_err) begin
        bus.err_adr_o <= bus.m_adr_i;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_interconnect_n.sv
// Directed self-checking bench for wishbone_interconnect_n (two slaves).
module tb_wishbone_interconnect_n;
  import wb_ic_pkg::*;

  localparam int NS = 2;
  localparam int TO = 16;

  logic   clk = 1'b0;
  logic   rst;
  state_t fsm_state;
  int     n_checks = 0;
  int     n_pass   = 0;

  always #5 clk = ~clk;

  wishbone_interconnect_n_if #(.NUM_SLAVES(NS)) bus ();

  wishbone_interconnect_n #(
    .NUM_SLAVES     (NS),
    .SEL_LSB        (24),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.m_we_i  = 1'b0;
    bus.s_ack_i = '0;
  endtask

  int          first_ack;
  int          n_acks;
  logic [31:0] cyc_at_ack;
  logic [31:0] berr_at_ack;

  initial begin
    rst         = 1'b1;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_dat_i = '0;
    bus.s_int_i = 2'b11;
    idle_bus();
    repeat (3) step();
    sample();
    check("rst_state",   32'(fsm_state),     32'd0);
    check("rst_cyc",     32'(bus.s_cyc_o),   32'd0);
    check("rst_ack",     32'(bus.m_ack_o),   32'd0);
    check("rst_dat",     bus.m_dat_o,        32'd0);
    check("rst_int",     32'(bus.m_int_o),   32'd0);
    check("rst_berr",    32'(bus.bus_err_o), 32'd0);
    check("rst_err_adr", bus.err_adr_o,      32'd0);
    step(); rst = 1'b0; bus.s_int_i = '0; sample();

    // Read slave 0, ack two cycles after its strobe, interrupt pulse mid-flight.
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0000_0004; sample();
    check("t1_decode_stb", 32'(bus.s_stb_o), 32'd0);
    check("t1_idle_state", 32'(fsm_state),   32'd0);
    step(); sample();
    check("t1_cyc",   32'(bus.s_cyc_o), 32'h1);
    check("t1_stb",   32'(bus.s_stb_o), 32'h1);
    check("t1_adr",   bus.s_adr_o,      32'h4);
    check("t1_noack", 32'(bus.m_ack_o), 32'd0);
    step(); bus.s_int_i = 2'b10; sample();
    check("t1_wait_ack", 32'(bus.m_ack_o), 32'd0);
    check("t1_int_pre",  32'(bus.m_int_o), 32'd0);
    step(); bus.s_int_i = '0; bus.s_ack_i = 2'b01;
    bus.s_dat_i = {32'hDEAD_BEEF, 32'h1234_5678}; sample();
    check("t1_ack",   32'(bus.m_ack_o), 32'd1);
    check("t1_rdata", bus.m_dat_o,      32'h1234_5678);
    check("t1_int",   32'(bus.m_int_o), 32'd1);
    step(); idle_bus(); sample();
    check("t1_int_post", 32'(bus.m_int_o), 32'd0);
    check("t1_cyc_drop", 32'(bus.s_cyc_o), 32'd0);

    // Write slave 1; a slave-0 ack is ignored and a mid-cycle address change keeps slave 1.
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_we_i = 1'b1;
    bus.m_adr_i = 32'h0100_0010; bus.m_dat_i = 32'hCAFE_BABE; sample();
    check("t2_decode_stb", 32'(bus.s_stb_o), 32'd0);
    step(); bus.s_ack_i = 2'b01; sample();
    check("t2_stb",       32'(bus.s_stb_o), 32'h2);
    check("t2_we",        32'(bus.s_we_o),  32'h2);
    check("t2_adr",       bus.s_adr_o,      32'h10);
    check("t2_dat",       bus.s_dat_o,      32'hCAFE_BABE);
    check("t2_other_ack", 32'(bus.m_ack_o), 32'd0);
    step(); bus.s_ack_i = 2'b10; bus.m_adr_i = 32'h0000_0020; sample();
    check("t2_latched", 32'(bus.s_stb_o), 32'h2);
    check("t2_ack",     32'(bus.m_ack_o), 32'd1);
    step(); idle_bus(); sample();

    // Unmapped read: error ack, then a second strobe in the same cycle gets its own error ack.
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0500_0000;
    bus.s_dat_i = {2{32'hFFFF_FFFF}}; bus.s_ack_i = 2'b01; sample();
    check("t3_idle_ack", 32'(bus.m_ack_o), 32'd0);
    step(); sample();
    check("t3_ack",     32'(bus.m_ack_o),   32'd1);
    check("t3_dat",     bus.m_dat_o,        32'd0);
    check("t3_berr",    32'(bus.bus_err_o), 32'd1);
    check("t3_nostb",   32'(bus.s_stb_o),   32'd0);
    check("t3_err_adr", bus.err_adr_o,      32'h0500_0000);
    step(); bus.m_stb_i = 1'b0; sample();
    check("t3_wait_ack",  32'(bus.m_ack_o),   32'd0);
    check("t3_wait_berr", 32'(bus.bus_err_o), 32'd0);
    step(); bus.m_stb_i = 1'b1; sample();
    check("t3_wait_state", 32'(fsm_state), 32'd3);
    step(); sample();
    check("t3_reack", 32'(bus.m_ack_o), 32'd1);
    step(); idle_bus(); sample();
    step(); sample();
    check("t3_idle", 32'(fsm_state), 32'd0);

    // Slave 1 never acks.
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0100_0000; sample();
    first_ack = -1; n_acks = 0; cyc_at_ack = '0; berr_at_ack = '0;
    for (int i = 1; i <= 1000; i++) begin
      step(); sample();
      if (bus.m_ack_o) begin
        n_acks++;
        if (first_ack < 0) begin
          first_ack   = i;
          cyc_at_ack  = 32'(bus.s_cyc_o);
          berr_at_ack = 32'(bus.bus_err_o);
        end
      end
      if (first_ack >= 0) break;
    end
`ifdef WB_IC_TIMEOUT_EN
    check("t4_ack_cycle", 32'(first_ack), 32'(TO + 1));
    check("t4_cyc_drop",  cyc_at_ack,     32'd0);
    check("t4_berr",      berr_at_ack,    32'd1);
    check("t4_err_adr",   bus.err_adr_o,  32'h0100_0000);
`else
    check("t4_no_ack",    32'(n_acks),      32'd0);
    check("t4_still_cyc", 32'(bus.s_cyc_o), 32'h2);
`endif
    step(); idle_bus(); sample();
    step(); sample();
    check("t4_idle", 32'(fsm_state), 32'd0);

    // Reset in the middle of an active transfer, then a normal transfer.
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0000_0008; sample();
    step(); sample();
    check("t5_active", 32'(bus.s_cyc_o), 32'h1);
    step(); rst = 1'b1; sample();
    step(); idle_bus(); sample();
    check("t5_rst_cyc",     32'(bus.s_cyc_o), 32'd0);
    check("t5_rst_ack",     32'(bus.m_ack_o), 32'd0);
    check("t5_rst_state",   32'(fsm_state),   32'd0);
    check("t5_rst_err_adr", bus.err_adr_o,    32'd0);
    step(); rst = 1'b0; sample();
    step(); bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0000_0100;
    bus.s_dat_i = {32'h0, 32'hA5A5_0001}; sample();
    step(); bus.s_ack_i = 2'b01; sample();
    check("t5_ack",   32'(bus.m_ack_o), 32'd1);
    check("t5_rdata", bus.m_dat_o,      32'hA5A5_0001);
    step(); idle_bus(); sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wishbone_interconnect_n.md
Name: wishbone_interconnect_n

Overview:
- Parametrised single-master, N-slave Wishbone interconnect; successor to the fixed two-slave interconnect.
- Sits between wishbone_master and the slave set: slave 0 is the device ROM table, slaves 1..N-1 are peripherals such as the tft core.
- Adds latched address decode, an error response for unmapped addresses, registered interrupt aggregation and an optional bus-timeout watchdog.

Parameters:
- NUM_SLAVES, 2: number of slave ports, 1..255.
- SEL_LSB, 24: LSB of the slave-select field in m_adr_i; the field is m_adr_i[31:SEL_LSB].
- TIMEOUT_CYCLES, 1024: strobe-without-ack cycles before a forced error ack. Used only with the timeout feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m_we_i  in  1  master write enable.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_adr_i  in  32  master address.
- m_dat_i  in  32  master write data.
- m_dat_o  out  32  read data to master.
- m_ack_o  out  1  ack to master.
- m_int_o  out  1  aggregated interrupt.
- s_we_o  out  NUM_SLAVES  per-slave write enable.
- s_cyc_o  out  NUM_SLAVES  per-slave cycle.
- s_stb_o  out  NUM_SLAVES  per-slave strobe.
- s_adr_o  out  32  shared slave address, select field zeroed.
- s_dat_o  out  32  shared write data, equal to m_dat_i.
- s_dat_i  in  32*NUM_SLAVES  flattened slave read data; slave k occupies [32k+31:32k].
- s_ack_i  in  NUM_SLAVES  per-slave ack.
- s_int_i  in  NUM_SLAVES  per-slave interrupt.
- bus_err_o  out  1  one-cycle pulse on an unmapped access or a timeout.
- err_adr_o  out  32  m_adr_i captured at the last error.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - s_cyc_o, s_stb_o, s_we_o = 0; m_ack_o = 0; m_dat_o = 0; m_int_o = 0; bus_err_o = 0; err_adr_o = 0.
  - Watchdog counter = 0; sel register = 0.
- FSM states: IDLE, ACTIVE, ERR_ACK, ERR_WAIT.
- IDLE:
  - On m_cyc_i & m_stb_i, register sel = m_adr_i[31:SEL_LSB].
  - sel < NUM_SLAVES: go to ACTIVE.
  - Otherwise: go to ERR_ACK and capture err_adr_o.
  - No slave signal is driven in IDLE. Decode costs exactly one cycle of added latency.
- ACTIVE:
  - s_cyc_o[sel] = m_cyc_i, s_stb_o[sel] = m_stb_i, s_we_o[sel] = m_we_i; all other bits 0.
  - m_ack_o = s_ack_i[sel] and m_dat_o = s_dat_i[sel] combinationally.
  - Stays in ACTIVE while m_cyc_i = 1. Strobes in a burst go to the latched slave even if the address select field changes mid-cycle.
  - m_cyc_i = 0: go to IDLE the same edge; slave cyc drops immediately.
- ERR_ACK:
  - m_ack_o = 1 for one cycle, m_dat_o = 0, bus_err_o = 1.
  - Writes are discarded.
  - Then go to ERR_WAIT.
- ERR_WAIT:
  - Hold until m_cyc_i = 0, then go to IDLE.
  - A new m_stb_i while m_cyc_i stays high re-enters ERR_ACK, with one ack per strobe.
- s_adr_o = m_adr_i with bits [31:SEL_LSB] forced to 0. s_dat_o = m_dat_i always.
- m_int_o: registered OR of s_int_i, one-cycle latency. An interrupt from any slave is visible regardless of FSM state.
- Acks outside ACTIVE, or from non-selected slaves, are ignored.
- m_cyc_i dropping in any state returns the FSM to IDLE next edge, except ERR_ACK, which always completes its one cycle.
- rst asserted mid-transaction: all slave strobes drop on the next edge and no ack is issued.

Optional Feature:
- Macro: WB_IC_TIMEOUT_EN.
- Defined:
  - In ACTIVE, the counter increments on each cycle with m_stb_i = 1 and s_ack_i[sel] = 0; it clears on ack or on leaving ACTIVE.
  - When it reaches TIMEOUT_CYCLES-1, the next cycle goes to ERR_ACK: slave cyc/stb deasserted, error ack given, err_adr_o captured.
- Undefined:
  - No counter logic; ACTIVE waits indefinitely.
  - bus_err_o reports unmapped accesses only.

Decomposition:
- Package wb_ic_pkg holds:
  - state encoding localparams (IDLE = 0, ACTIVE = 1, ERR_ACK = 2, ERR_WAIT = 3);
  - error read-data constant (32'h0);
  - address field width constant (32).
- One natural sub-module: wb_ic_decode.
  - Combinational select-field extract and range check.
  - Outputs sel_idx and sel_valid.
- FSM, mux and watchdog stay in the top.

Test Plan:
- Read 0x00000004 with slave0 acking 2 cycles after stb and data 0x12345678 -> s_cyc_o = 2'b01, s_adr_o = 0x4, m_dat_o = 0x12345678 with m_ack_o; first slave stb one cycle after master stb.
- Write 0x01000010 = 0xCAFEBABE, NUM_SLAVES = 2 -> only s_stb_o[1] asserted, s_adr_o = 0x10, s_dat_o = 0xCAFEBABE, ack returned.
- Read 0x05000000 with NUM_SLAVES = 2 -> no slave strobe, m_ack_o pulses once with m_dat_o = 0, bus_err_o = 1, err_adr_o = 0x05000000.
- With WB_IC_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave1 never acks -> error ack after 16+1 cycles, s_cyc_o[1] drops, bus_err_o = 1. Without the macro, no ack after 1000 cycles.
- s_int_i[1] pulsed 1 cycle while a slave0 transfer is in flight -> m_int_o high exactly 1 cycle, delayed by 1.
- rst asserted during ACTIVE -> all s_cyc_o = 0 next edge, m_ack_o = 0, FSM in IDLE; next transfer completes normally.
